// File: rtl/addsub_arbiter.sv
// Round-robin arbiter that shares one external add/subtract unit between NUM_REQ requesters.
// One transaction at a time: IDLE -> ISSUE -> WAIT -> RESP, with a WAIT timeout.
module addsub_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ-1:0]       req_sub,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       ack,
    output logic [WIDTH-1:0]         rsp_data,
    output logic                     rsp_err,
    output logic                     busy,
    output logic                     au_start,
    output logic [WIDTH-1:0]         au_a,
    output logic [WIDTH-1:0]         au_b,
    output logic                     au_sub,
    input  logic                     au_done,
    input  logic [WIDTH-1:0]         au_result
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sub_q, sub_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_err_q, rsp_err_d;

    logic             sel_vld;
    logic [IW-1:0]    sel_idx;
    logic [NUM_REQ-1:0] idx_oh;

    // Search starts one past the last winner so held requests rotate.
    always_comb begin
        int j;
        j       = 0;
        sel_vld = 1'b0;
        sel_idx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            j = int'(ptr_q) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!sel_vld && req[j]) begin
                sel_vld = 1'b1;
                sel_idx = IW'(j);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        ptr_d      = ptr_q;
        a_d        = a_q;
        b_d        = b_q;
        sub_d      = sub_q;
        cnt_d      = cnt_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (sel_vld) begin
                    idx_d   = sel_idx;
                    a_d     = req_a[sel_idx*WIDTH +: WIDTH];
                    b_d     = req_b[sel_idx*WIDTH +: WIDTH];
                    sub_d   = req_sub[sel_idx];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (au_done) begin
                    rsp_data_d = au_result;
                    rsp_err_d  = 1'b0;
                    state_d    = RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = RESP;
                end
            end
            RESP: begin
                ptr_d   = idx_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            ptr_q      <= IW'(NUM_REQ - 1);
            a_q        <= '0;
            b_q        <= '0;
            sub_q      <= 1'b0;
            cnt_q      <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            ptr_q      <= ptr_d;
            a_q        <= a_d;
            b_q        <= b_d;
            sub_q      <= sub_d;
            cnt_q      <= cnt_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    // Decoded from state so an async reset clears them at once.
    assign idx_oh   = NUM_REQ'(1) << idx_q;
    assign gnt      = (state_q != IDLE) ? idx_oh : '0;
    assign ack      = (state_q == RESP) ? idx_oh : '0;
    assign busy     = (state_q != IDLE);
    assign au_start = (state_q == ISSUE);
    assign au_a     = a_q;
    assign au_b     = b_q;
    assign au_sub   = sub_q;
    assign rsp_data = rsp_data_q;
    assign rsp_err  = rsp_err_q;

endmodule

// File: doc/addsub_arbiter.md
Name: addsub_arbiter

Overview:
- Shares one external 16-bit add/subtract unit (the SUM/SUB provider feeding the square-root datapath) between up to NUM_REQ requesters, e.g. SQRT, divider and multiplier sequencers.
- Arbitrates round-robin, latches the winner's operands, and issues one operation to the unit.
- Waits for completion or timeout, then returns the result to the winner with a one-cycle ack.

Parameters:
- NUM_REQ, 3, number of requesters (2..8)
- WIDTH, 16, operand/result width
- TIMEOUT, 16, max WAIT cycles before the transaction is aborted (>=2)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-low reset
- req  in  NUM_REQ  per-requester request level
- req_a  in  NUM_REQ*WIDTH  operand A; slot i = bits [i*WIDTH +: WIDTH]
- req_b  in  NUM_REQ*WIDTH  operand B, same packing
- req_sub  in  NUM_REQ  1 = A-B, 0 = A+B
- gnt  out  NUM_REQ  one-hot grant, high ISSUE through RESP
- ack  out  NUM_REQ  one-cycle pulse, response valid
- rsp_data  out  WIDTH  result; valid with ack, held until next RESP
- rsp_err  out  1  timeout flag; valid with ack
- busy  out  1  high when state != IDLE
- au_start  out  1  one-cycle start pulse to the unit
- au_a, au_b  out  WIDTH  latched operands, stable ISSUE through RESP
- au_sub  out  1  latched op select
- au_done  in  1  unit completion
- au_result  in  WIDTH  unit result, valid with au_done

Behaviour:
- Reset (rst=0, async): state=IDLE; gnt, ack, rsp_data, rsp_err, busy, au_start, au_a, au_b, au_sub all 0; ptr=NUM_REQ-1; timeout counter=0.
- Reset mid-transaction abandons the transaction: no ack is issued and au_start drops immediately.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req is high, select the first high index searching (ptr+1) mod NUM_REQ upward with wrap.
  - Latch idx, that slot's a, b and sub; go to ISSUE. Otherwise stay.
- ISSUE (1 cycle): au_start=1; gnt[idx]=1; clear timeout counter; go to WAIT. au_done is ignored in ISSUE.
- WAIT: counter increments each cycle.
  - au_done=1: latch au_result into rsp_data, set rsp_err=0, go to RESP.
  - Else if counter==TIMEOUT-1: rsp_data=0, rsp_err=1, go to RESP.
  - au_done has priority over timeout in the same cycle.
- RESP (1 cycle): ack[idx]=1, gnt[idx]=1; ptr<=idx; go to IDLE.
- Latency: req first sampled high in IDLE at cycle t -> au_start at t+1 -> earliest ack at t+3 (au_done at t+2); worst case t+2+TIMEOUT.
- Requester protocol:
  - Holds req and operands until ack.
  - req still high in the IDLE cycle after ack counts as a new request. Continuously held reqs therefore rotate fairly.
  - Dropping req after capture does not cancel the transaction: ack is still issued.
  - Operand changes after capture have no effect.
- Outputs: gnt and ack are at most one-hot. au_a, au_b and au_sub keep their last values in IDLE. busy=0 only in IDLE.
- Arithmetic: performed only by the external unit; the block passes WIDTH bits unmodified with no width extension.

Test Plan:
- Single requester: req[0]=1, a=0x0010, b=0x0003, sub=1; unit model returns 0x000D one cycle after au_start -> au_start at t+1 with au_a=0x0010, au_b=0x0003, au_sub=1; ack=3'b001 at t+3, rsp_data=0x000D, rsp_err=0, gnt low after t+3.
- Simultaneous requests from reset, all req held, unit 1-cycle -> grants in order 0,1,2,0,1,2 with one IDLE cycle between transactions; each ack carries the matching slot's A+B.
- Fairness: req[0] and req[2] held, req[1]=0 -> grant order 0,2,0,2; req[1] raised during grant to 2 -> next grant is 0, then 1.
- Timeout: TIMEOUT=8, au_done never asserted -> ack at t+2+8 with rsp_err=1, rsp_data=0x0000; next request completes normally with rsp_err=0.
- Reset during WAIT: rst low for 2 cycles -> all outputs 0 asynchronously, no ack; then req[1] and req[0] raised together -> req[0] granted first.
- Spurious done: au_done pulsed in ISSUE cycle, real au_done 3 cycles later with 0x1234 -> the ISSUE pulse is ignored; ack follows the real done, rsp_data=0x1234.
